gpu_rect_engine: RTL and testbench
==================================

Name: gpu_rect_engine

Overview:
- Second-generation rectangle raster engine for the GPU command path.
- Latches two corner points, a colour and a draw mode from the AXI4-Lite register front-end.
- Rasterises the rectangle into the framebuffer write port, one pixel per accepted beat.
- New over the first generation:
  - filled and outline modes;
  - framebuffer back-pressure (ready);
  - abort;
  - multiplier-free incremental addressing;
  - a cycle-accurate pixel counter.

Parameters:
- FRAME_WIDTH_SCALED, 640, frame width in pixels.
- FRAME_HEIGHT_SCALED, 480, frame height in pixels.
- COORD_WIDTH, 12, coordinate bit width.
- COLOR_WIDTH, 8, colour bit width.
- FBUF_ADDR_WIDTH, 19, framebuffer address width.
- FBUF_DATA_WIDTH, 8, framebuffer data width; must be >= COLOR_WIDTH, colour is zero-extended.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin draw (single-cycle pulse).
- abort  in  1  cancel a draw in progress.
- busy  out  1  high while SETUP or BUSY.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.
- left_valid  in  1  left corner write strobe.
- left_x, left_y  in  COORD_WIDTH each  left corner coordinates.
- right_valid  in  1  right corner write strobe.
- right_x, right_y  in  COORD_WIDTH each  right corner coordinates.
- color_valid  in  1  colour write strobe.
- color  in  COLOR_WIDTH  colour value.
- mode_valid  in  1  mode write strobe.
- mode  in  1  draw mode: 0 = fill, 1 = outline.
- fbuf_ready  in  1  framebuffer accepts the current beat.
- fbuf_en_wr  out  1  write enable.
- fbuf_wrea  out  1  byte write strobe (mirrors fbuf_en_wr).
- fbuf_addr  out  FBUF_ADDR_WIDTH  pixel address.
- fbuf_data  out  FBUF_DATA_WIDTH  pixel data.
- pix_count  out  FBUF_ADDR_WIDTH+1  pixels accepted in the current or last draw.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state IDLE;
  - all outputs 0;
  - all latched operands and valid flags 0;
  - mode defaults to fill.
- States: IDLE, SETUP, BUSY, DONE, ERR.
- IDLE, operand capture:
  - Each *_valid strobe latches its operand and sets its internal flag.
  - A corner with x >= FRAME_WIDTH_SCALED or y >= FRAME_HEIGHT_SCALED is not latched; the state goes to ERR.
  - The mode flag is optional; mode persists until a DONE/ERR clear.
- IDLE, start:
  - start evaluates the flags as registered before this edge. An operand strobed in the same cycle is captured but not used.
  - All of left, right and colour flags set -> SETUP. Otherwise -> ERR.
  - Out-of-range capture and start in the same cycle -> ERR (one err pulse).
- SETUP, one cycle:
  - Register min/max per axis.
  - Register row_base = min_y*FRAME_WIDTH_SCALED, the only multiply in the block.
  - Set pos to (min_x, min_y). Clear pix_count.
  - -> BUSY.
- BUSY:
  - fbuf_en_wr = fbuf_wrea = 1.
  - fbuf_addr = row_base + pos_x, truncated to FBUF_ADDR_WIDTH.
  - fbuf_data = colour.
  - Address, data and enable stay stable while fbuf_ready = 0.
  - Position advances only on an accepted beat (fbuf_ready = 1); pix_count increments on each accepted beat.
- Scan order: x within a row, then y.
  - At row end: pos_x <= min_x, pos_y +1, row_base += FRAME_WIDTH_SCALED.
- Outline mode:
  - First and last rows are drawn fully.
  - Interior rows emit min_x then max_x only: after min_x, pos_x jumps to max_x.
  - If min_x == max_x, each interior row emits one pixel; no duplicate write.
- Termination: an accepted beat at (max_x, max_y) -> DONE.
  - Degenerate 1x1 rectangle: one beat.
- Pixel counts:
  - Fill: (dx+1)*(dy+1).
  - Outline: fill count when dy <= 1 or dx <= 1; otherwise 2*(dx+1) + 2*(dy-1).
- abort in BUSY or SETUP:
  - -> ERR next edge; no further beats are presented.
  - abort beats a simultaneous final accept, which still counts in pix_count.
  - abort in IDLE is ignored.
- DONE / ERR:
  - Each lasts one cycle and clears all operands, flags and mode, then -> IDLE.
  - pix_count holds until the next SETUP.
- Framebuffer outputs are 0 outside BUSY.
- rst mid-draw: IDLE on the next edge, enable drops immediately at that edge, no done or err pulse.

Optional Feature:
- Macro: GPU_RECT_CLIP_EN.
- Defined: out-of-range corner coordinates are clamped to FRAME_WIDTH_SCALED-1 / FRAME_HEIGHT_SCALED-1 on capture, and no ERR is raised.
- Undefined: out-of-range coordinates raise ERR as described under Behaviour.

Decomposition:
- Package gpu_pkg holds:
  - the state enum (rect_state_t);
  - the mode enum (draw_mode_t: DRAW_FILL, DRAW_OUTLINE);
  - the default frame-size constants.
- One sub-module, gpu_rect_scan:
  - contents: the pos/row_base counters and the outline skip logic;
  - inputs: load, advance, min/max, mode;
  - outputs: addr, last.
- Operand latching and the FSM stay in the top module.

Test Plan:
1. Fill with left=(2,3), right=(5,4), colour 0x5A, fbuf_ready tied high -> 8 beats at addresses 1922..1925 and 2562..2565; done pulses on the cycle after the last beat; pix_count = 8.
2. Outline with left=(10,10), right=(13,13) -> 12 beats; interior rows write only x=10 and x=13; pix_count = 12.
3. Same fill as scenario 1 with fbuf_ready toggling 1,0,0,1,... -> address and data held during stalls; still 8 accepted beats in order.
4. start with colour never written -> err pulse one cycle later; no fbuf_en_wr; all flags cleared.
5. left_x = 700:
   - macro undefined -> err pulse;
   - GPU_RECT_CLIP_EN defined -> clamped to 639, and the draw completes.
6. abort after 3 accepted beats of a 4x4 fill -> ERR, pix_count = 3; rst asserted mid-draw -> IDLE with no pulse.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and default frame geometry for the rectangle raster engine.
package gpu_pkg;

    localparam int DEFAULT_FRAME_WIDTH  = 640;
    localparam int DEFAULT_FRAME_HEIGHT = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_BUSY,
        ST_DONE,
        ST_ERR
    } rect_state_t;

    typedef enum logic {
        DRAW_FILL    = 1'b0,
        DRAW_OUTLINE = 1'b1
    } draw_mode_t;

endpackage

// File: rtl/gpu_rect_scan.sv
// Rectangle scan walker: x within a row, then y, with outline interior-row skipping.
// Addressing is incremental; the only multiply happens once on load.
module gpu_rect_scan
    import gpu_pkg::*;
#(
    parameter int FRAME_WIDTH_SCALED = DEFAULT_FRAME_WIDTH,
    parameter int COORD_WIDTH        = 12,
    parameter int FBUF_ADDR_WIDTH    = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       advance,
    input  logic [COORD_WIDTH-1:0]     min_x,
    input  logic [COORD_WIDTH-1:0]     min_y,
    input  logic [COORD_WIDTH-1:0]     max_x,
    input  logic [COORD_WIDTH-1:0]     max_y,
    input  draw_mode_t                 mode,
    output logic [FBUF_ADDR_WIDTH-1:0] addr,
    output logic                       last
);

    localparam logic [FBUF_ADDR_WIDTH-1:0] ROW_STRIDE = FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED);

    logic [COORD_WIDTH-1:0]     pos_x;
    logic [COORD_WIDTH-1:0]     pos_y;
    logic [FBUF_ADDR_WIDTH-1:0] row_base;
    logic                       row_end;
    logic                       interior_row;

    assign row_end      = (pos_x == max_x);
    assign last         = row_end && (pos_y == max_y);
    assign interior_row = (mode == DRAW_OUTLINE) && (pos_y != min_y) && (pos_y != max_y);
    assign addr         = row_base + FBUF_ADDR_WIDTH'(pos_x);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x    <= '0;
            pos_y    <= '0;
            row_base <= '0;
        end else if (load) begin
            pos_x    <= min_x;
            pos_y    <= min_y;
            row_base <= FBUF_ADDR_WIDTH'(min_y) * ROW_STRIDE;
        end else if (advance) begin
            if (row_end) begin
                pos_x    <= min_x;
                pos_y    <= pos_y + COORD_WIDTH'(1);
                row_base <= row_base + ROW_STRIDE;
            end else if (interior_row && (pos_x == min_x)) begin
                // Outline interior rows only need their two edge pixels.
                pos_x <= max_x;
            end else begin
                pos_x <= pos_x + COORD_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/gpu_rect_engine.sv
// Rectangle raster engine: operand capture, draw FSM and framebuffer write port.
// Build option GPU_RECT_CLIP_EN clamps out-of-range corners instead of raising an error.
module gpu_rect_engine
    import gpu_pkg::*;
#(
    parameter int FRAME_WIDTH_SCALED  = DEFAULT_FRAME_WIDTH,
    parameter int FRAME_HEIGHT_SCALED = DEFAULT_FRAME_HEIGHT,
    parameter int COORD_WIDTH         = 12,
    parameter int COLOR_WIDTH         = 8,
    parameter int FBUF_ADDR_WIDTH     = 19,
    parameter int FBUF_DATA_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       left_valid,
    input  logic [COORD_WIDTH-1:0]     left_x,
    input  logic [COORD_WIDTH-1:0]     left_y,
    input  logic                       right_valid,
    input  logic [COORD_WIDTH-1:0]     right_x,
    input  logic [COORD_WIDTH-1:0]     right_y,
    input  logic                       color_valid,
    input  logic [COLOR_WIDTH-1:0]     color,
    input  logic                       mode_valid,
    input  logic                       mode,
    input  logic                       fbuf_ready,
    output logic                       fbuf_en_wr,
    output logic                       fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
    output logic [FBUF_ADDR_WIDTH:0]   pix_count
);

    localparam logic [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(FRAME_WIDTH_SCALED - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(FRAME_HEIGHT_SCALED - 1);

    rect_state_t state_q, state_d;

    logic [COORD_WIDTH-1:0] left_x_q, left_y_q, right_x_q, right_y_q;
    logic [COLOR_WIDTH-1:0] color_q;
    draw_mode_t             mode_q;
    logic                   left_ok, right_ok, color_ok;

    logic                   left_take, right_take, range_err;
    logic [COORD_WIDTH-1:0] left_x_cap, left_y_cap, right_x_cap, right_y_cap;

`ifdef GPU_RECT_CLIP_EN
    assign left_x_cap  = (left_x  > X_MAX) ? X_MAX : left_x;
    assign left_y_cap  = (left_y  > Y_MAX) ? Y_MAX : left_y;
    assign right_x_cap = (right_x > X_MAX) ? X_MAX : right_x;
    assign right_y_cap = (right_y > Y_MAX) ? Y_MAX : right_y;
    assign left_take   = left_valid;
    assign right_take  = right_valid;
    assign range_err   = 1'b0;
`else
    logic left_oor, right_oor;
    assign left_oor    = (left_x  > X_MAX) || (left_y  > Y_MAX);
    assign right_oor   = (right_x > X_MAX) || (right_y > Y_MAX);
    assign left_x_cap  = left_x;
    assign left_y_cap  = left_y;
    assign right_x_cap = right_x;
    assign right_y_cap = right_y;
    assign left_take   = left_valid  && !left_oor;
    assign right_take  = right_valid && !right_oor;
    assign range_err   = (left_valid && left_oor) || (right_valid && right_oor);
`endif

    // Operands are only written in IDLE and wiped by the DONE/ERR cycle.
    always_ff @(posedge clk) begin
        if (rst || (state_q == ST_DONE) || (state_q == ST_ERR)) begin
            left_x_q  <= '0;
            left_y_q  <= '0;
            right_x_q <= '0;
            right_y_q <= '0;
            color_q   <= '0;
            mode_q    <= DRAW_FILL;
            left_ok   <= 1'b0;
            right_ok  <= 1'b0;
            color_ok  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (left_take) begin
                left_x_q <= left_x_cap;
                left_y_q <= left_y_cap;
                left_ok  <= 1'b1;
            end
            if (right_take) begin
                right_x_q <= right_x_cap;
                right_y_q <= right_y_cap;
                right_ok  <= 1'b1;
            end
            if (color_valid) begin
                color_q  <= color;
                color_ok <= 1'b1;
            end
            if (mode_valid) begin
                mode_q <= draw_mode_t'(mode);
            end
        end
    end

    logic [COORD_WIDTH-1:0] min_x_c, min_y_c, max_x_c, max_y_c;
    logic [COORD_WIDTH-1:0] min_x_q, min_y_q, max_x_q, max_y_q;

    assign min_x_c = (left_x_q <= right_x_q) ? left_x_q  : right_x_q;
    assign max_x_c = (left_x_q <= right_x_q) ? right_x_q : left_x_q;
    assign min_y_c = (left_y_q <= right_y_q) ? left_y_q  : right_y_q;
    assign max_y_c = (left_y_q <= right_y_q) ? right_y_q : left_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            {min_x_q, min_y_q, max_x_q, max_y_q} <= '0;
        end else if (state_q == ST_SETUP) begin
            min_x_q <= min_x_c;
            min_y_q <= min_y_c;
            max_x_q <= max_x_c;
            max_y_q <= max_y_c;
        end
    end

    logic                       load, accept, scan_last;
    logic [FBUF_ADDR_WIDTH-1:0] scan_addr;

    assign load   = (state_q == ST_SETUP);
    assign accept = (state_q == ST_BUSY) && fbuf_ready;

    // SETUP loads the scanner from the live bounds while the registered copies are written.
    gpu_rect_scan #(
        .FRAME_WIDTH_SCALED (FRAME_WIDTH_SCALED),
        .COORD_WIDTH        (COORD_WIDTH),
        .FBUF_ADDR_WIDTH    (FBUF_ADDR_WIDTH)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (accept),
        .min_x   (load ? min_x_c : min_x_q),
        .min_y   (load ? min_y_c : min_y_q),
        .max_x   (load ? max_x_c : max_x_q),
        .max_y   (load ? max_y_c : max_y_q),
        .mode    (mode_q),
        .addr    (scan_addr),
        .last    (scan_last)
    );

    // The final beat still counts even when abort wins the transition.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            pix_count <= '0;
        end else if (accept) begin
            pix_count <= pix_count + (FBUF_ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        fbuf_en_wr = 1'b0;
        fbuf_wrea  = 1'b0;
        fbuf_addr  = '0;
        fbuf_data  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (range_err) begin
                    state_d = ST_ERR;
                end else if (start) begin
                    state_d = (left_ok && right_ok && color_ok) ? ST_SETUP : ST_ERR;
                end
            end
            ST_SETUP: begin
                busy    = 1'b1;
                state_d = abort ? ST_ERR : ST_BUSY;
            end
            ST_BUSY: begin
                busy       = 1'b1;
                fbuf_en_wr = 1'b1;
                fbuf_wrea  = 1'b1;
                fbuf_addr  = scan_addr;
                fbuf_data  = FBUF_DATA_WIDTH'(color_q);
                if (abort) begin
                    state_d = ST_ERR;
                end else if (accept && scan_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpu_rect_engine.sv
// Scoreboard bench for gpu_rect_engine: a pixel-enumerating model queues the expected beats,
// a negedge monitor checks every accepted framebuffer beat against the queue.
module tb_gpu_rect_engine;
    import gpu_pkg::*;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int CW = 12;
    localparam int LW = 8;
    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic          busy, done, err;
    logic          left_valid, right_valid, color_valid, mode_valid, mode;
    logic [CW-1:0] left_x, left_y, right_x, right_y;
    logic [LW-1:0] color;
    logic          fbuf_ready = 1'b0;
    logic          fbuf_en_wr, fbuf_wrea;
    logic [AW-1:0] fbuf_addr;
    logic [DW-1:0] fbuf_data;
    logic [AW:0]   pix_count;

    gpu_rect_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .left_valid  (left_valid),
        .left_x      (left_x),
        .left_y      (left_y),
        .right_valid (right_valid),
        .right_x     (right_x),
        .right_y     (right_y),
        .color_valid (color_valid),
        .color       (color),
        .mode_valid  (mode_valid),
        .mode        (mode),
        .fbuf_ready  (fbuf_ready),
        .fbuf_en_wr  (fbuf_en_wr),
        .fbuf_wrea   (fbuf_wrea),
        .fbuf_addr   (fbuf_addr),
        .fbuf_data   (fbuf_data),
        .pix_count   (pix_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acc_count = 0;
    int    last_beat_cyc = 0;
    int    ready_mode = 0;
    int    ready_phase = 0;
    logic  stalled = 1'b0;
    logic [AW-1:0] held_addr = '0;
    logic [DW-1:0] held_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // 0: always ready, 1: random, 2: repeating 1,0,0
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: fbuf_ready = 1'b1;
            1: fbuf_ready = 1'($urandom_range(0, 1));
            default: begin
                fbuf_ready  = (ready_phase == 0);
                ready_phase = (ready_phase + 1) % 3;
            end
        endcase
    end

    always @(negedge clk) begin
        if (fbuf_en_wr) begin
            check("wrea_mirror", 64'(fbuf_wrea), 64'(1));
            if (stalled) begin
                check("stall_addr_hold", 64'(fbuf_addr), 64'(held_addr));
                check("stall_data_hold", 64'(fbuf_data), 64'(held_data));
            end
            if (fbuf_ready) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    check("beat_addr", 64'(fbuf_addr), 64'(exp_q[0].addr));
                    check("beat_data", 64'(fbuf_data), 64'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
                acc_count     <= acc_count + 1;
                last_beat_cyc <= cyc;
                stalled       <= 1'b0;
            end else begin
                stalled   <= 1'b1;
                held_addr <= fbuf_addr;
                held_data <= fbuf_data;
            end
        end else begin
            stalled <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_corner(input bit right_side, input int x, input int y);
        if (right_side) begin
            right_valid = 1'b1; right_x = CW'(x); right_y = CW'(y);
        end else begin
            left_valid = 1'b1; left_x = CW'(x); left_y = CW'(y);
        end
        tick();
        left_valid  = 1'b0;
        right_valid = 1'b0;
    endtask

    task automatic set_color(input int c);
        color_valid = 1'b1; color = LW'(c);
        tick();
        color_valid = 1'b0;
    endtask

    task automatic set_mode(input int m);
        mode_valid = 1'b1; mode = 1'(m);
        tick();
        mode_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    // Reference: enumerate every pixel of the rectangle, keep those belonging to the shape.
    task automatic push_expected(input int lx, input int ly, input int rx, input int ry,
                                 input int col, input bit outline, output int count);
        int x0, x1, y0, y1, dx, dy;
        beat_t b;
        lx = clampi(lx, W-1); rx = clampi(rx, W-1);
        ly = clampi(ly, H-1); ry = clampi(ry, H-1);
        x0 = (lx < rx) ? lx : rx; x1 = (lx < rx) ? rx : lx;
        y0 = (ly < ry) ? ly : ry; y1 = (ly < ry) ? ry : ly;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (!outline || y == y0 || y == y1 || x == x0 || x == x1) begin
                    b.addr = AW'(y * W + x);
                    b.data = DW'(col);
                    exp_q.push_back(b);
                end
            end
        end
        dx = x1 - x0;
        dy = y1 - y0;
        count = (outline && dx > 1 && dy > 1) ? 2*(dx+1) + 2*(dy-1) : (dx+1)*(dy+1);
    endtask

    // mode_sel: -1 leaves mode unwritten (defaults to fill), 0 fill, 1 outline.
    task automatic run_draw(input string tag, input int lx, input int ly, input int rx, input int ry,
                            input int col, input int mode_sel, input int rdy);
        int  count;
        bit  seen, bad;
        ready_mode = rdy;
        set_corner(0, lx, ly);
        set_corner(1, rx, ry);
        set_color(col);
        if (mode_sel >= 0) set_mode(mode_sel);
        push_expected(lx, ly, rx, ry, col, mode_sel == 1, count);
        pulse_start();
        seen = 0;
        bad  = 0;
        for (int i = 0; i < 4000 && !seen && !bad; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1;
            if (err)  bad  = 1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
        check({tag, "_done_latency"}, 64'(cyc - last_beat_cyc), 64'(1));
        check({tag, "_beats_left"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_pix_count"}, 64'(pix_count), 64'(count));
        check({tag, "_busy_low"}, 64'(busy), 64'(0));
        tick();
        check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
        exp_q.delete();
    endtask

    task automatic expect_err_now(input string tag);
        check({tag, "_err_pulse"}, 64'(err), 64'(1));
        check({tag, "_no_write"}, 64'(fbuf_en_wr), 64'(0));
        tick();
        check({tag, "_err_one_cycle"}, 64'(err), 64'(0));
    endtask

    task automatic wait_beats(input string tag, input int target);
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (acc_count >= target) ok = 1;
        end
        check({tag, "_beats_reached"}, 64'(ok), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, count;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        left_valid = 1'b0; right_valid = 1'b0; color_valid = 1'b0; mode_valid = 1'b0; mode = 1'b0;
        left_x = '0; left_y = '0; right_x = '0; right_y = '0; color = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_en", 64'(fbuf_en_wr), 64'(0));
        check("reset_addr", 64'(fbuf_addr), 64'(0));
        check("reset_pix", 64'(pix_count), 64'(0));

        run_draw("fill", 2, 3, 5, 4, 'h5A, -1, 0);
        run_draw("outline", 10, 10, 13, 13, 'h33, 1, 0);
        run_draw("fill_stall", 2, 3, 5, 4, 'h5A, 0, 2);
        run_draw("one_pixel", 7, 9, 7, 9, 'hC1, 1, 1);
        run_draw("column_outline", 20, 5, 20, 9, 'h11, 1, 1);
        run_draw("corner_swap", 639, 479, 636, 476, 'hEE, 1, 2);

        // Missing colour, then a lone colour after the clear.
        set_corner(0, 1, 1);
        set_corner(1, 4, 4);
        pulse_start();
        expect_err_now("no_color");
        set_color('h44);
        pulse_start();
        expect_err_now("flags_cleared");

`ifdef GPU_RECT_CLIP_EN
        run_draw("clip", 700, 5, 636, 6, 'h77, 0, 0);
`else
        set_corner(0, 700, 5);
        expect_err_now("left_oor");
        set_corner(1, 3, 3);
        set_color('h12);
        pulse_start();
        expect_err_now("oor_not_latched");
`endif

        // Abort with the third beat: it is still counted, nothing follows.
        ready_mode = 0;
        set_corner(0, 20, 20);
        set_corner(1, 23, 23);
        set_color('h9C);
        push_expected(20, 20, 23, 23, 'h9C, 0, count);
        base = acc_count;
        pulse_start();
        wait_beats("abort", base + 2);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_pix_count", 64'(pix_count), 64'(3));
        check("abort_beats_left", 64'(exp_q.size()), 64'(count - 3));
        expect_err_now("abort");
        repeat (3) tick();
        check("abort_pix_hold", 64'(pix_count), 64'(3));
        exp_q.delete();

        // Reset mid-draw: straight to idle, no pulses.
        set_corner(0, 30, 30);
        set_corner(1, 37, 33);
        set_color('h21);
        push_expected(30, 30, 37, 33, 'h21, 0, count);
        base = acc_count;
        pulse_start();
        wait_beats("rst_mid", base + 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("rst_mid_en", 64'(fbuf_en_wr), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        check("rst_mid_err", 64'(err), 64'(0));
        check("rst_mid_pix", 64'(pix_count), 64'(0));
        tick();
        check("rst_mid_no_late_pulse", 64'(done | err), 64'(0));

        for (int n = 0; n < 12; n++) begin
            int x0, y0, x1, y1;
            x0 = $urandom_range(0, W-1);
            y0 = $urandom_range(0, H-1);
            x1 = clampi(x0 + $urandom_range(0, 6), W-1);
            y1 = clampi(y0 + $urandom_range(0, 5), H-1);
            if ($urandom_range(0, 1) == 1) run_draw("rand", x1, y1, x0, y0, $urandom_range(0, 255),
                                                    $urandom_range(0, 2) - 1, $urandom_range(0, 2));
            else                           run_draw("rand", x0, y1, x1, y0, $urandom_range(0, 255),
                                                    $urandom_range(0, 2) - 1, $urandom_range(0, 2));
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
